// File: rtl/jtglfgreat_adc_pkg.sv
// Shared definitions for the ADC0834-style serial converter model:
// FSM encoding, field widths and mux-address bit positions.
package jtglfgreat_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_NULL,
        ST_MSB,
        ST_LSB,
        ST_DONE
    } adc_state_t;

    localparam int ADDR_BITS = 3;
    localparam int DATA_BITS = 8;

    // Mux address bits in shift order: SGL arrives first and ends up on top.
    localparam int POS_SGL  = 2;
    localparam int POS_ODD  = 1;
    localparam int POS_SEL1 = 0;

endpackage

// File: rtl/jtglfgreat_adc_mux.sv
// Channel select for the converter: single-ended pick or saturating
// differential subtract between an even/odd channel pair.
module jtglfgreat_adc_mux
    import jtglfgreat_adc_pkg::*;
#(
    parameter int DIFF_EN = 1
) (
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_BITS-1:0] i_ch0,
    input  logic [DATA_BITS-1:0] i_ch1,
    input  logic [DATA_BITS-1:0] i_ch2,
    input  logic [DATA_BITS-1:0] i_ch3,
    output logic [DATA_BITS-1:0] o_result
);

    logic                 w_sgl;
    logic [DATA_BITS-1:0] w_single;
    logic [DATA_BITS-1:0] w_even;
    logic [DATA_BITS-1:0] w_odd;
    logic [DATA_BITS:0]   w_diff;

    assign w_sgl = (DIFF_EN == 0) ? 1'b1 : i_addr[POS_SGL];

    always_comb begin
        w_single = i_ch0;
        case ({i_addr[POS_SEL1], i_addr[POS_ODD]})
            2'd0:    w_single = i_ch0;
            2'd1:    w_single = i_ch1;
            2'd2:    w_single = i_ch2;
            default: w_single = i_ch3;
        endcase
    end

    assign w_even = i_addr[POS_SEL1] ? i_ch2 : i_ch0;
    assign w_odd  = i_addr[POS_SEL1] ? i_ch3 : i_ch1;

    // Extra bit catches the borrow so a negative difference clamps to zero.
    assign w_diff = i_addr[POS_ODD] ? ({1'b0, w_odd}  - {1'b0, w_even})
                                    : ({1'b0, w_even} - {1'b0, w_odd});

    assign o_result = w_sgl      ? w_single :
                      w_diff[DATA_BITS] ? '0 : w_diff[DATA_BITS-1:0];

endmodule

// File: rtl/jtglfgreat_adc.sv
// ADC0834-class serial A/D emulation: synchronises the CPU-driven pins,
// decodes the mux address and shifts the latched sample out on dout.
module jtglfgreat_adc
    import jtglfgreat_adc_pkg::*;
#(
    parameter logic IDLE_DO = 1'b1,
    parameter int   DIFF_EN = 1
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 adc_cs_n,
    input  logic                 adc_sclk,
    input  logic                 adc_di,
    input  logic [DATA_BITS-1:0] ch0,
    input  logic [DATA_BITS-1:0] ch1,
    input  logic [DATA_BITS-1:0] ch2,
    input  logic [DATA_BITS-1:0] ch3,
    output logic                 dout
);

    logic                 r_cs_n;
    logic                 r_sclk;
    logic                 r_sclk_d;
    logic                 r_di;

    adc_state_t           r_state,    w_state_nx;
    logic [ADDR_BITS-1:0] r_addr,     w_addr_nx;
    logic [1:0]           r_addr_cnt, w_addr_cnt_nx;
    logic [2:0]           r_bit_cnt,  w_bit_cnt_nx;
    logic [DATA_BITS-1:0] r_result,   w_result_nx;
    logic                 r_dout,     w_dout_nx;

    logic                 w_rise;
    logic                 w_fall;
    logic [ADDR_BITS-1:0] w_addr_shift;
    logic [DATA_BITS-1:0] w_mux_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_n   <= 1'b1;
            r_sclk   <= 1'b0;
            r_sclk_d <= 1'b0;
            r_di     <= 1'b0;
        end else begin
            r_cs_n   <= adc_cs_n;
            r_sclk   <= adc_sclk;
            r_sclk_d <= r_sclk;
            r_di     <= adc_di;
        end
    end

    assign w_rise       = r_sclk & ~r_sclk_d;
    assign w_fall       = ~r_sclk & r_sclk_d;
    assign w_addr_shift = {r_addr[ADDR_BITS-2:0], r_di};

    // Fed with the address as it will look after this edge's shift, so the
    // sample is captured on the same cycle as the third address bit.
    jtglfgreat_adc_mux #(
        .DIFF_EN (DIFF_EN)
    ) u_mux (
        .i_addr   (w_addr_shift),
        .i_ch0    (ch0),
        .i_ch1    (ch1),
        .i_ch2    (ch2),
        .i_ch3    (ch3),
        .o_result (w_mux_result)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_addr_nx     = r_addr;
        w_addr_cnt_nx = r_addr_cnt;
        w_bit_cnt_nx  = r_bit_cnt;
        w_result_nx   = r_result;
        w_dout_nx     = r_dout;

        if (r_cs_n) begin
            w_state_nx = ST_IDLE;
            w_dout_nx  = IDLE_DO;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_START;
                    w_dout_nx  = 1'b0;
                end
                ST_START: begin
                    w_dout_nx = 1'b0;
                    if (w_rise && r_di) begin
                        w_state_nx    = ST_ADDR;
                        w_addr_nx     = '0;
                        w_addr_cnt_nx = '0;
                    end
                end
                ST_ADDR: begin
                    if (w_rise) begin
                        w_addr_nx = w_addr_shift;
                        if (r_addr_cnt == 2'(ADDR_BITS - 1)) begin
                            w_result_nx = w_mux_result;
                            w_state_nx  = ST_NULL;
                        end else begin
                            w_addr_cnt_nx = r_addr_cnt + 2'd1;
                        end
                    end
                end
                ST_NULL: begin
                    if (w_fall) begin
                        w_dout_nx    = 1'b0;
                        w_bit_cnt_nx = 3'(DATA_BITS - 1);
                        w_state_nx   = ST_MSB;
                    end
                end
                ST_MSB: begin
                    if (w_fall) begin
                        w_dout_nx = r_result[r_bit_cnt];
                        if (r_bit_cnt == 3'd0) begin
                            w_bit_cnt_nx = 3'd1;
                            w_state_nx   = ST_LSB;
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt - 3'd1;
                        end
                    end
                end
                ST_LSB: begin
                    if (w_fall) begin
                        w_dout_nx = r_result[r_bit_cnt];
                        if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
                            w_state_nx = ST_DONE;
                        end else begin
                            w_bit_cnt_nx = r_bit_cnt + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_fall) begin
                        w_dout_nx = 1'b0;
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_dout_nx  = IDLE_DO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_addr_cnt <= '0;
            r_bit_cnt  <= '0;
            r_result   <= '0;
            r_dout     <= IDLE_DO;
        end else begin
            r_state    <= w_state_nx;
            r_addr     <= w_addr_nx;
            r_addr_cnt <= w_addr_cnt_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_result   <= w_result_nx;
            r_dout     <= w_dout_nx;
        end
    end

    assign dout = r_dout;

endmodule
